// File: rtl/soc_reset_ctrl.sv
// soc_reset_ctrl: button debounce, manualReset pulse stretcher, halt/restart FSM.
// Optional: SOC_RESET_CTRL_AUTO_RESTART_EN compiles in WAIT and auto restart.
module soc_reset_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int RESET_HOLD_CYCLES = 8,
  parameter int RESTART_DELAY     = 32
) (
  input  logic       sysClock,
  input  logic       reset,
  input  logic       button_n,
  input  logic       halt,
  input  logic       auto_restart,
  output logic       manualReset,
  output logic       halted,
  output logic [7:0] restart_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(RESET_HOLD_CYCLES - 1);

`ifdef SOC_RESET_CTRL_AUTO_RESTART_EN
  localparam int LW = $clog2(RESTART_DELAY + 1);
  localparam logic [LW-1:0] LMAX = LW'(RESTART_DELAY - 1);

  typedef enum logic [1:0] {
    ST_RESET, ST_RUN, ST_HALTED, ST_WAIT
  } state_t;

  logic [LW-1:0] dly_q, dly_d;
`else
  typedef enum logic [1:0] {
    ST_RESET, ST_RUN, ST_HALTED
  } state_t;

  logic unused_auto;
  assign unused_auto = auto_restart & (RESTART_DELAY > 0);
`endif

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          press_q, press_d;
  logic          mrst_q, halted_q;
  logic [7:0]    cnt_q;
  logic          entry;

  // Synchronizer and debounce registers; press is a registered pulse.
  always_ff @(posedge sysClock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      dcnt_q  <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= button_n;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      press_q <= press_d;
    end
  end

  // Accept a new level only after it differed for the full window.
  always_comb begin
    deb_d   = deb_q;
    dcnt_d  = '0;
    press_d = 1'b0;
    if (sync2_q != deb_q) begin
      if (dcnt_q == DMAX) begin
        deb_d   = sync2_q;
        press_d = !sync2_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  // Sequencer state and counters.
  always_ff @(posedge sysClock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RESET;
      hold_q  <= HMAX;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

`ifdef SOC_RESET_CTRL_AUTO_RESTART_EN
  // Restart delay counter.
  always_ff @(posedge sysClock or negedge reset) begin
    if (!reset) dly_q <= '0;
    else        dly_q <= dly_d;
  end
`endif

  // Next state; a press overrides everything, including halt.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
`ifdef SOC_RESET_CTRL_AUTO_RESTART_EN
    dly_d   = dly_q;
`endif
    unique case (state_q)
      ST_RESET: begin
        if (hold_q == '0) state_d = ST_RUN;
        else              hold_d  = hold_q - 1'b1;
      end
      ST_RUN: begin
        if (halt) state_d = ST_HALTED;
      end
      ST_HALTED: begin
`ifdef SOC_RESET_CTRL_AUTO_RESTART_EN
        if (auto_restart) begin
          state_d = ST_WAIT;
          dly_d   = LMAX;
        end
`endif
      end
`ifdef SOC_RESET_CTRL_AUTO_RESTART_EN
      ST_WAIT: begin
        if (!auto_restart) begin
          state_d = ST_HALTED;
        end else if (dly_q == '0) begin
          state_d = ST_RESET;
          hold_d  = HMAX;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_RESET;
        hold_d  = HMAX;
      end
    endcase
    if (press_q) begin
      state_d = ST_RESET;
      hold_d  = HMAX;
    end
  end

  assign entry = (state_d == ST_RESET) && (state_q != ST_RESET);

  // Registered outputs derived from the next state.
  always_ff @(posedge sysClock or negedge reset) begin
    if (!reset) begin
      mrst_q   <= 1'b1;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mrst_q   <= (state_d == ST_RESET);
      halted_q <= (state_d != ST_RESET) && (state_d != ST_RUN);
      if (entry && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign manualReset   = mrst_q;
  assign halted        = halted_q;
  assign restart_count = cnt_q;

endmodule

// File: doc/soc_reset_ctrl.md
# soc_reset_ctrl

Reset and halt sequencer sitting between the board's reset button, the CPU halt output and the `SoC` top. It debounces the raw active-low button, stretches every reset request into a fixed-length active-high `manualReset` pulse for `SoC`, tracks the halt condition, and can restart the SoC automatically after a programmable delay. It is the synthesizable replacement for the reset/halt sequencing done ad hoc in the simulation top.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16: cycles the synchronized button level must be stable before it is accepted (>=2).
- `RESET_HOLD_CYCLES`, 8: `manualReset` pulse length in cycles (>=1).
- `RESTART_DELAY`, 32: cycles spent in HALTED before an automatic restart (>=1).

Ports:
- `sysClock` in 1: system clock. One clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `button_n` in 1: raw reset button, active low, asynchronous to `sysClock`.
- `halt` in 1: CPU halt from `SoC`, active high, synchronous.
- `auto_restart` in 1: 1 = restart automatically after halt, synchronous, level.
- `manualReset` out 1: active-high reset to `SoC`.
- `halted` out 1: 1 while in HALTED or WAIT.
- `restart_count` out 8: count of reset pulses issued since `reset`, saturating.

## Operation
- Button path: 2-flop synchronizer, then debouncer. The debounced level changes only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles. `press` is a one-cycle pulse on a debounced 1->0 transition. A held button gives exactly one press. Release is debounced the same way.
- States:
  - RESET: `manualReset`=1. The hold counter counts down from `RESET_HOLD_CYCLES`-1. At 0, go to RUN.
  - RUN: `manualReset`=0. `halt`=1 goes to HALTED.
  - HALTED: `halted`=1. If `auto_restart`=1, load the delay counter with `RESTART_DELAY`-1 and go to WAIT. Otherwise stay.
  - WAIT: `halted`=1. Count down. At 0, go to RESET. If `auto_restart` drops, return to HALTED.
- `press` in any state: go to RESET and reload the hold counter. `press` has priority over `halt`. `press` during RESET restarts the pulse.
- `halt` is ignored in RESET, HALTED and WAIT.
- `restart_count` increments by 1 on each entry to RESET, except the entry caused by `reset`. It saturates at 255.

## Timing
- During `reset` low, asynchronously: state=RESET, `manualReset`=1, `halted`=0, `restart_count`=0, hold counter=`RESET_HOLD_CYCLES`-1, debounced level=1, synchronizer flops=1.
- After `reset` releases: `manualReset` stays 1 for exactly `RESET_HOLD_CYCLES` rising edges, then drops.
- Button latency: `button_n` falling to `press` takes 2 + `DEBOUNCE_CYCLES` cycles. `manualReset` rises on the edge after `press`.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no press.
- `halt` sampled high in RUN: `halted`=1 after 1 edge.
- With `auto_restart` held at 1: the halt edge is followed by 1 cycle in HALTED and `RESTART_DELAY` cycles in WAIT, then `manualReset`=1 for `RESET_HOLD_CYCLES` cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `SOC_RESET_CTRL_AUTO_RESTART_EN` defined: the WAIT state, the delay counter and the `auto_restart` behaviour are compiled in as described.
- Not defined: the `auto_restart` port remains but is ignored. HALTED is left only by `press`. WAIT and the delay counter are not generated. `RESTART_DELAY` is unused.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `RESET_HOLD_CYCLES`=3, `RESTART_DELAY`=5.
- Release `reset` -> `manualReset`=1 for exactly 3 edges, then 0. `restart_count`=0, `halted`=0.
- Pulse `button_n` low for 3 cycles -> no press, `manualReset` stays 0. Hold low for 20 cycles -> exactly one 3-cycle pulse, starting 7 cycles after the fall, and `restart_count`=1.
- In RUN with `auto_restart`=1, raise `halt` for one cycle -> `halted`=1 for 6 cycles, then `manualReset`=1 for 3 cycles, then RUN, `halted`=0, `restart_count` incremented.
- Same as the previous scenario with `auto_restart`=0 -> `halted` stays 1 indefinitely. A debounced press -> RESET pulse, then RUN. With the macro undefined, `auto_restart`=1 behaves identically.
- `press` and `halt` in the same cycle in RUN -> RESET, not HALTED. A second press during RESET -> the pulse is extended to 3 cycles from the second press.
- Issue 300 presses -> `restart_count`=255. Assert `reset` mid-pulse -> all outputs return to their reset values immediately (asynchronously).
